// File: rtl/axi_burst_writer.sv
// axi_burst_writer
//   AXI4 write master that packs an incoming byte stream into 32-bit
//   little-endian words and writes them to memory in INCR bursts that never
//   cross a 4 KB boundary. Only one burst is outstanding at a time.
//
// Ports
//   CLK, RST_N           clock, synchronous active-low reset
//   start                launch pulse (ignored while busy)
//   base_addr            start byte address (bits [1:0] ignored)
//   word_count           number of 32-bit words to write
//   busy, done, error    status: in progress, end-of-transfer pulse,
//                        sticky bad-response flag (cleared by start)
//   in_valid/in_ready/in_data   byte stream input
//   aw*                  AXI write address channel (awid/awsize/awburst fixed)
//   w*                   AXI write data channel (full strobes)
//   b*                   AXI write response channel (bid ignored)
module axi_burst_writer #(
  parameter int unsigned ID_WIDTH  = 6,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic [31:0]         base_addr,
  input  logic [15:0]         word_count,
  output logic                busy,
  output logic                done,
  output logic                error,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [ID_WIDTH-1:0] awid,
  output logic                wvalid,
  input  logic                wready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [ID_WIDTH-1:0] bid,
  input  logic [1:0]          bresp
);

  localparam int unsigned LW = $clog2(MAX_BURST) + 1;
  localparam int unsigned PW = $clog2(MAX_BURST);

  typedef enum logic [2:0] {IDLE, FILL, ADDR, DATA, RESP} state_t;

  state_t        state_q, state_d;
  logic [29:0]   addr_q;        // word address, byte address bits [31:2]
  logic [15:0]   remaining_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_calc;
  logic [LW-1:0] beat_q;
  logic [17:0]   byte_cnt_q;
  logic [17:0]   byte_limit_q;
  logic [23:0]   partial_q;
  logic [31:0]   mem [MAX_BURST];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] fill_q;
  logic          done_q;
  logic          error_q;
  logic          take;
  logic          push;
  logic          pop;
  logic [10:0]   room;
  logic [16:0]   len_wide;
  logic          unused_ok;

  assign unused_ok = ^{bid, base_addr[1:0]};

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign error    = error_q;
  assign awsize   = 3'b010;
  assign awburst  = 2'b01;
  assign awid     = '0;
  assign in_ready = busy && (fill_q != LW'(MAX_BURST)) && (byte_cnt_q < byte_limit_q);
  assign take     = in_valid && in_ready;
  assign push     = take && (byte_cnt_q[1:0] == 2'b11);
  assign pop      = (state_q == DATA) && wready;

  // Next burst length: smallest of remaining words, burst cap and words left
  // before the next 4 KB page (1024 - word offset within the page).
  always_comb begin
    room     = 11'd1024 - {1'b0, addr_q[9:0]};
    len_wide = {1'b0, remaining_q};
    if (len_wide > 17'(MAX_BURST)) len_wide = 17'(MAX_BURST);
    if (len_wide > {6'd0, room})   len_wide = {6'd0, room};
    len_calc = LW'(len_wide);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    awvalid = 1'b0;
    awaddr  = '0;
    awlen   = '0;
    wvalid  = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wlast   = 1'b0;
    bready  = 1'b0;
    case (state_q)
      IDLE: if (start && (word_count != '0)) state_d = FILL;
      // Waiting for a whole burst of words keeps W free of data stalls.
      FILL: if (fill_q >= len_calc) state_d = ADDR;
      ADDR: begin
        awvalid = 1'b1;
        awaddr  = {addr_q, 2'b00};
        awlen   = 8'(len_q - LW'(1));
        if (awready) state_d = DATA;
      end
      DATA: begin
        wvalid = 1'b1;
        wdata  = mem[rd_ptr_q];
        wstrb  = 4'hF;
        wlast  = (beat_q == len_q - LW'(1));
        if (wready && wlast) state_d = RESP;
      end
      RESP: begin
        bready = 1'b1;
        if (bvalid) state_d = (remaining_q == 16'(len_q)) ? IDLE : FILL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      byte_cnt_q   <= '0;
      byte_limit_q <= '0;
      partial_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          addr_q       <= base_addr[31:2];
          remaining_q  <= word_count;
          byte_limit_q <= {word_count, 2'b00};
          byte_cnt_q   <= '0;
          error_q      <= 1'b0;
          if (word_count == '0) done_q <= 1'b1;
        end
        FILL: if (fill_q >= len_calc) len_q <= len_calc;
        ADDR: if (awready) beat_q <= '0;
        DATA: if (wready) beat_q <= beat_q + LW'(1);
        RESP: if (bvalid) begin
          if (bresp != 2'b00) error_q <= 1'b1;
          addr_q      <= addr_q + 30'(len_q);
          remaining_q <= remaining_q - 16'(len_q);
          if (remaining_q == 16'(len_q)) done_q <= 1'b1;
        end
        default: ;
      endcase

      if (take) begin
        byte_cnt_q <= byte_cnt_q + 18'd1;
        case (byte_cnt_q[1:0])
          2'd0:    partial_q[7:0]   <= in_data;
          2'd1:    partial_q[15:8]  <= in_data;
          2'd2:    partial_q[23:16] <= in_data;
          default: ;
        endcase
      end

      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + LW'(1);
        2'b01:   fill_q <= fill_q - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= {in_data, partial_q};
  end

endmodule

// File: tb/tb_axi_burst_writer.sv
module tb_axi_burst_writer;
  localparam int unsigned IDW = 6;
  localparam int unsigned MB  = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N, start, busy, done, error, in_valid, in_ready;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic [7:0] in_data;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst, bresp;
  logic [3:0] wstrb;
  logic [IDW-1:0] awid, bid;

  axi_burst_writer #(.ID_WIDTH(IDW), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .error(error),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned len;
  } burst_t;

  typedef struct {
    logic [31:0] base;
    logic [15:0] count;
    bit          stall;
    int          bad;
    bit          inc;
    int          restart_at;
    bit          lat;
    int          exp_bursts;
    bit          exp_err;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  burst_t      exp_q[$];
  logic [7:0]  mem_m [bit [31:0]];
  logic [7:0]  stream[$];
  int unsigned idx, acc, aw_cnt, done_cnt, done_cyc, first_aw_cyc, last_byte_cyc, lb_at_aw;
  int unsigned beat, cur_len, b_idx;
  int          bad_burst;
  bit          stall, pending_b, in_burst, aw_wait, in_ready_seen, awvalid_seen;
  bit          start_req, rst_n_req;
  logic [31:0] req_base, cur_addr, aw_prev_addr;
  logic [15:0] req_count;
  logic [7:0]  aw_prev_len;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference burst plan: split the word range into pieces capped by MB and
  // by the distance to the next 4 KB page.
  function automatic int build_model(input logic [31:0] base, input logic [15:0] count);
    logic [31:0] a;
    int unsigned rem, len, room;
    exp_q.delete();
    a   = base & ~32'h3;
    rem = count;
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / 4;
      len  = rem;
      if (len > MB)   len = MB;
      if (len > room) len = room;
      exp_q.push_back('{a, len});
      a   = a + 32'(4 * len);
      rem = rem - len;
    end
    return exp_q.size();
  endfunction

  task automatic clear_model();
    idx = 0; acc = 0; aw_cnt = 0; done_cnt = 0; b_idx = 0; beat = 0; cur_len = 0;
    pending_b = 0; in_burst = 0; aw_wait = 0; in_ready_seen = 0; awvalid_seen = 0;
    first_aw_cyc = 0; last_byte_cyc = 0; lb_at_aw = 0; done_cyc = 0;
    mem_m.delete();
  endtask

  // One clock: drive inputs at the falling edge, then record the handshakes
  // that the next rising edge will complete.
  task automatic step();
    @(negedge CLK);
    cyc++;
    RST_N      = rst_n_req;
    start      = start_req;
    base_addr  = req_base;
    word_count = req_count;
    start_req  = 0;
    awready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    bvalid  = pending_b && (bvalid || !stall || ($urandom_range(0, 2) == 0));
    bresp   = (int'(b_idx) == bad_burst) ? 2'b10 : 2'b00;
    if (idx < stream.size() && (!stall || $urandom_range(0, 3) != 0)) begin
      in_valid = 1'b1;
      in_data  = stream[idx];
    end else begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end

    if (in_ready) in_ready_seen = 1;
    if (awvalid)  awvalid_seen = 1;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_at_done", busy, 1'b0);
    end
    if (aw_wait) check("aw_hold", {awvalid, awaddr, awlen}, {1'b1, aw_prev_addr, aw_prev_len});
    aw_wait      = awvalid && !awready;
    aw_prev_addr = awaddr;
    aw_prev_len  = awlen;

    if (in_burst) begin
      check("wvalid_hold", wvalid, 1'b1);
      if (wvalid && wready) begin
        for (int k = 0; k < 4; k++) mem_m[cur_addr + 32'(4 * beat + k)] = wdata[8*k +: 8];
        check("wlast", wlast, (beat == cur_len - 1));
        check("wstrb", wstrb, 4'hF);
        beat++;
        if (beat == cur_len) begin
          in_burst  = 0;
          pending_b = 1;
        end
      end
    end else begin
      check("wvalid_idle", wvalid, 1'b0);
    end

    if (awvalid && awready) begin
      aw_cnt++;
      if (aw_cnt == 1) begin
        first_aw_cyc = cyc;
        lb_at_aw     = last_byte_cyc;
      end
      if (exp_q.size() > 0) begin
        burst_t e;
        e = exp_q.pop_front();
        check("awaddr", awaddr, e.addr);
        check("awlen", awlen, 8'(e.len - 1));
      end
      check("aw_const", {awsize, awburst, awid}, {3'b010, 2'b01, {IDW{1'b0}}});
      cur_addr = awaddr;
      cur_len  = int'(awlen) + 1;
      beat     = 0;
      in_burst = 1;
    end

    if (bvalid && bready) begin
      pending_b = 0;
      b_idx++;
    end

    if (in_valid && in_ready) begin
      idx++;
      acc++;
      last_byte_cyc = cyc;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ctl", {awvalid, wvalid, bready, in_ready, busy, done, error, wlast}, 8'h00);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_awlen", awlen, 8'h0);
    check("rst_wdata", wdata, 32'h0);
  endtask

  task automatic run_xfer(input logic [31:0] base, input logic [15:0] count, input bit stl,
                          input int bad, input bit inc, input int restart_at, input bit lat,
                          input int exp_bursts, input bit exp_err);
    int nb;
    int unsigned mism;
    int unsigned start_cyc;
    clear_model();
    nb = build_model(base, count);
    stream.delete();
    for (int i = 0; i < 4 * int'(count) + 4; i++) stream.push_back(inc ? 8'(i) : 8'($urandom));
    stall     = stl;
    bad_burst = bad;
    start_req = 1;
    req_base  = base;
    req_count = count;
    step();
    start_cyc = cyc;
    for (int n = 0; n < 6000 && done_cnt == 0; n++) begin
      if (restart_at > 0 && n == restart_at) begin
        start_req = 1;
        req_base  = 32'hDEAD_0000;
        req_count = 16'd7;
      end
      step();
      if (n == 0) check("error_clear", error, 1'b0);
    end
    check("done_seen", done_cnt, 1);
    for (int n = 0; n < 3; n++) step();
    check("done_pulse", done_cnt, 1);
    check("error", error, exp_err);
    check("bursts_model", aw_cnt, nb);
    if (exp_bursts >= 0) check("bursts_table", aw_cnt, exp_bursts);
    check("bytes_accepted", acc, 4 * int'(count));
    mism = 0;
    for (int i = 0; i < 4 * int'(count); i++) begin
      logic [31:0] a;
      a = (base & ~32'h3) + 32'(i);
      if (!mem_m.exists(a)) mism++;
      else if (mem_m[a] !== stream[i]) mism++;
    end
    check("mem_data", mism, 0);
    check("mem_extent", mem_m.size(), 4 * int'(count));
    if (count == 0) begin
      check("done_latency", done_cyc - start_cyc, 1);
      check("no_awvalid", awvalid_seen, 1'b0);
      check("no_in_ready", in_ready_seen, 1'b0);
    end
    if (lat) begin
      check("aw_latency", first_aw_cyc - lb_at_aw, 2);
      check("burst_latency", done_cyc - first_aw_cyc, int'(count) + 2);
    end
  endtask

  vec_t vecs[8];

  initial begin
    bit found;
    vecs[0] = '{32'h1000_0000, 16'd4,  1'b0, -1, 1'b1, 0,   1'b1, 1, 1'b0};
    vecs[1] = '{32'h1000_0FF8, 16'd20, 1'b0, -1, 1'b1, 0,   1'b0, 3, 1'b0};
    vecs[2] = '{32'h2000_0000, 16'd0,  1'b0, -1, 1'b1, 0,   1'b0, 0, 1'b0};
    vecs[3] = '{32'h3000_0100, 16'd37, 1'b1, -1, 1'b0, 0,   1'b0, 3, 1'b0};
    vecs[4] = '{32'h4000_0000, 16'd60, 1'b0,  1, 1'b0, 150, 1'b0, 4, 1'b1};
    vecs[5] = '{32'h5000_0000, 16'd4,  1'b0, -1, 1'b0, 0,   1'b0, 1, 1'b0};
    vecs[6] = '{32'hFFFF_FFF0, 16'd8,  1'b1, -1, 1'b0, 0,   1'b0, 2, 1'b0};
    vecs[7] = '{32'h7000_0FFB, 16'd3,  1'b1, -1, 1'b0, 0,   1'b0, 2, 1'b0};

    RST_N = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bid = '0; bresp = '0;
    rst_n_req = 0; start_req = 0; req_base = '0; req_count = '0;
    stall = 0; bad_burst = -1;
    clear_model();

    repeat (3) step();
    check_reset_outputs();
    rst_n_req = 1;

    for (int v = 0; v < 8; v++)
      run_xfer(vecs[v].base, vecs[v].count, vecs[v].stall, vecs[v].bad, vecs[v].inc,
               vecs[v].restart_at, vecs[v].lat, vecs[v].exp_bursts, vecs[v].exp_err);

    // Reset while the third data beat of a burst is on the bus.
    clear_model();
    void'(build_model(32'h6000_0000, 16'd8));
    stream.delete();
    for (int i = 0; i < 40; i++) stream.push_back(8'(i));
    stall = 0; bad_burst = -1;
    start_req = 1; req_base = 32'h6000_0000; req_count = 16'd8;
    found = 0;
    for (int n = 0; n < 500 && !found; n++) begin
      step();
      if (in_burst && beat == 2) found = 1;
    end
    check("reach_beat3", found, 1'b1);
    rst_n_req = 0;
    step();
    rst_n_req = 1;
    clear_model();
    exp_q.delete();
    stream.delete();
    step();
    check_reset_outputs();
    run_xfer(32'h6000_0000, 16'd8, 1'b0, -1, 1'b0, 0, 1'b0, 1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      logic [31:0] b;
      logic [15:0] c;
      int bad, nb;
      bit e;
      b = $urandom;
      if (r % 2 == 0) b[11:4] = 8'hFF;
      c   = 16'($urandom_range(1, 40));
      bad = int'($urandom_range(0, 3)) - 1;
      nb  = build_model(b, c);
      e   = (bad >= 0) && (bad < nb);
      run_xfer(b, c, 1'b1, bad, 1'b0, 0, 1'b0, -1, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
